// File: rtl/seq_multdiv.sv
// Multi-cycle signed 32-bit multiplier / divider.
// Operands are latched as magnitudes on the start edge. A single 64-bit
// accumulator performs 32 radix-2 steps: shift-add for multiply and
// restoring shift-subtract for divide. The sign is applied once at the end.
module seq_multdiv #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int W  = WIDTH;
    localparam int CW = $clog2(ITERS);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;     // mult: {partial, multiplier}; div: {rem, dividend/quotient}
    logic [W-1:0]     opb_q, opb_d;     // mult: |multiplicand|; div: |divisor|
    logic             neg_q, neg_d;
    logic [W-1:0]     res_q, res_d;
    logic             exc_q, exc_d;

    // A pulse on exactly one of the two controls starts an operation
    logic             start;
    logic [W-1:0]     mag_a, mag_b;
    logic [W:0]       mul_sum, rem, diff;
    logic [2*W-1:0]   acc_mul, acc_div, acc_step, prod_s;
    logic [W-1:0]     quo_s;
    logic             last;
    logic [W-1:0]     fin_res;
    logic             fin_exc;

    assign start = ctrl_mult ^ ctrl_div;
    assign last  = (cnt_q == CW'(ITERS - 1));

    // One iteration of either algorithm, plus sign/exception fix-up of the final value
    always_comb begin
        mag_a   = data_operandA[W-1] ? -data_operandA : data_operandA;
        mag_b   = data_operandB[W-1] ? -data_operandB : data_operandB;

        // Shift-add: add multiplicand when the current multiplier bit is set, shift right
        mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        acc_mul = {mul_sum, acc_q[W-1:1]};

        // Restoring divide: shift left, keep the subtraction only if it did not go negative
        rem     = acc_q[2*W-1:W-1];
        diff    = rem - {1'b0, opb_q};
        acc_div = diff[W] ? {acc_q[2*W-2:0], 1'b0}
                          : {diff[W-1:0], acc_q[W-2:0], 1'b1};

        acc_step = (state_q == DIV) ? acc_div : acc_mul;

        // Negating a zero magnitude yields zero, so zero operands never produce -0
        prod_s  = neg_q ? -acc_step : acc_step;
        quo_s   = neg_q ? -acc_step[W-1:0] : acc_step[W-1:0];

        fin_res = '0;
        fin_exc = 1'b0;
        if (state_q == DIV) begin
            if (opb_q == '0) begin
                fin_res = '0;
                fin_exc = 1'b1;
            end else begin
                // Only MIN / -1 produces a positive quotient with the top bit set
                fin_res = quo_s;
                fin_exc = ~neg_q & acc_step[W-1];
            end
        end else begin
            fin_res = prod_s[W-1:0];
            fin_exc = (prod_s[2*W-1:W] != {W{prod_s[W-1]}});
        end
    end

    // Next-state: start/restart from any state, iterate, present result, return to idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        res_d   = res_q;
        exc_d   = exc_q;
        if (start) begin
            state_d = ctrl_mult ? MULT : DIV;
            cnt_d   = '0;
            neg_d   = data_operandA[W-1] ^ data_operandB[W-1];
            if (ctrl_mult) begin
                acc_d = {{W{1'b0}}, mag_b};
                opb_d = mag_a;
            end else begin
                acc_d = {{W{1'b0}}, mag_a};
                opb_d = mag_b;
            end
        end else begin
            case (state_q)
                MULT, DIV: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        res_d   = fin_res;
                        exc_d   = fin_exc;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_seq_multdiv.sv
// Scoreboard bench for seq_multdiv: expected results are queued at start and
// checked whenever the RDY strobe is seen.
module tb_seq_multdiv;

    logic        clk, clr_n, ctrl_mult, ctrl_div;
    logic [31:0] data_operandA, data_operandB, data_result;
    logic        data_exception, data_resultRDY, busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [32:0] sb_q[$];   // {exception, result}

    seq_multdiv #(.WIDTH(32), .ITERS(32)) dut (
        .clk(clk), .clr_n(clr_n), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] model(input logic mult, input logic [31:0] a, input logic [31:0] b);
        longint pa, pb, p;
        int     q;
        logic [31:0] lo;
        if (mult) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            p  = pa * pb;
            lo = p[31:0];
            return {(p != longint'($signed(lo))), lo};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    // Scoreboard: every RDY strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (clr_n && data_resultRDY === 1'b1) begin
            logic [32:0] exp_v;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL rdy_unexpected: got result %h exc %b, queue empty", data_result, data_exception);
            end else begin
                exp_v = sb_q.pop_front();
                if ({data_exception, data_result} !== exp_v) begin
                    n_err++;
                    $display("FAIL rdy_result: got exc %b result %h, exp exc %b result %h",
                             data_exception, data_result, exp_v[32], exp_v[31:0]);
                end
            end
        end
    end

    // Drive a one-cycle start pulse beginning now; returns #1 after the start edge
    task automatic pulse(input logic mult, input logic [31:0] a, input logic [31:0] b, input logic push);
        ctrl_mult     = mult;
        ctrl_div      = ~mult;
        data_operandA = a;
        data_operandB = b;
        if (push) sb_q.push_back(model(mult, a, b));
        @(posedge clk); #1;
        ctrl_mult     = 1'b0;
        ctrl_div      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Start an op and observe 40 edges: first RDY edge index, RDY count, busy cycles
    task automatic run_op(input logic mult, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int nrdy, output int nbusy);
        @(posedge clk); #1;
        pulse(mult, a, b, 1'b1);
        lat = 0; nrdy = 0; nbusy = (busy === 1'b1) ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (data_resultRDY === 1'b1) begin
                nrdy++;
                if (lat == 0) lat = i;
            end
            if (busy === 1'b1) nbusy++;
        end
    endtask

    task automatic test_reset();
        ctrl_mult = 0; ctrl_div = 0; data_operandA = 0; data_operandB = 0;
        clr_n = 1'b0;
        #12;
        n_cmp++; if (data_result !== 32'd0)  begin n_err++; $display("FAIL reset_result: got %h exp 0", data_result); end
        n_cmp++; if (data_exception !== 1'b0) begin n_err++; $display("FAIL reset_exc: got %b exp 0", data_exception); end
        n_cmp++; if (data_resultRDY !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b exp 0", data_resultRDY); end
        n_cmp++; if (busy !== 1'b0)           begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
        @(negedge clk); clr_n = 1'b1;
    endtask

    task automatic test_mult();
        int lat, nrdy, nbusy;
        run_op(1'b1, 32'd7, 32'hFFFF_FFFD, lat, nrdy, nbusy);
        n_cmp++; if (lat !== 32)  begin n_err++; $display("FAIL mult_latency: got %0d exp 32", lat); end
        n_cmp++; if (nrdy !== 1)  begin n_err++; $display("FAIL mult_rdy_width: got %0d exp 1", nrdy); end
        n_cmp++; if (nbusy !== 33) begin n_err++; $display("FAIL mult_busy_cycles: got %0d exp 33", nbusy); end
        run_op(1'b1, 32'h0001_0000, 32'h0001_0000, lat, nrdy, nbusy);
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nrdy, nbusy);
        run_op(1'b1, 32'd0, 32'hFFFF_FFFB, lat, nrdy, nbusy);
        run_op(1'b1, 32'h8000_0000, 32'd1, lat, nrdy, nbusy);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, nrdy, nbusy);
    endtask

    task automatic test_div();
        int lat, nrdy, nbusy;
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, lat, nrdy, nbusy);
        n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL div_latency: got %0d exp 32", lat); end
        run_op(1'b0, 32'd100, 32'd0, lat, nrdy, nbusy);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, nrdy, nbusy);
        run_op(1'b0, 32'd0, 32'hFFFF_FFFB, lat, nrdy, nbusy);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, lat, nrdy, nbusy);
        run_op(1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFE, lat, nrdy, nbusy);
    endtask

    task automatic test_random();
        int lat, nrdy, nbusy;
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            b = (i % 2) ? ($urandom % 2000) - 1000 : $urandom;
            run_op(logic'(i % 2 == 0), $urandom, b, lat, nrdy, nbusy);
            n_cmp++; if (nrdy !== 1) begin n_err++; $display("FAIL random_rdy_count[%0d]: got %0d exp 1", i, nrdy); end
        end
    endtask

    task automatic test_abort();
        int lat = 0, nrdy = 0;
        @(posedge clk); #1;
        pulse(1'b1, 32'd5, 32'd5, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        pulse(1'b0, 32'd20, 32'd4, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (data_resultRDY === 1'b1) begin
                nrdy++;
                if (lat == 0) lat = i;
            end
        end
        n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL abort_latency: got %0d exp 32", lat); end
        n_cmp++; if (nrdy !== 1) begin n_err++; $display("FAIL abort_rdy_count: got %0d exp 1", nrdy); end
        n_cmp++; if (data_result !== 32'd5) begin n_err++; $display("FAIL abort_result: got %h exp 5", data_result); end
    endtask

    task automatic test_clear();
        int nrdy = 0;
        @(posedge clk); #1;
        pulse(1'b1, 32'd7, 32'd7, 1'b0);
        repeat (14) @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        n_cmp++; if (data_result !== 32'd0)  begin n_err++; $display("FAIL clear_result: got %h exp 0", data_result); end
        n_cmp++; if (data_exception !== 1'b0) begin n_err++; $display("FAIL clear_exc: got %b exp 0", data_exception); end
        n_cmp++; if (busy !== 1'b0)           begin n_err++; $display("FAIL clear_busy: got %b exp 0", busy); end
        n_cmp++; if (data_resultRDY !== 1'b0) begin n_err++; $display("FAIL clear_rdy: got %b exp 0", data_resultRDY); end
        @(negedge clk); clr_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (data_resultRDY !== 1'b0) nrdy++;
        end
        n_cmp++; if (nrdy !== 0) begin n_err++; $display("FAIL clear_no_rdy: got %0d exp 0", nrdy); end
        // Both controls together must be ignored
        ctrl_mult = 1'b1; ctrl_div = 1'b1;
        data_operandA = 32'd3; data_operandB = 32'd3;
        @(posedge clk); #1;
        ctrl_mult = 1'b0; ctrl_div = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL both_ctrl_busy: got %b exp 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL both_ctrl_busy_later: got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        pulse(1'b1, 32'd1234, 32'hFFFF_FF00, 1'b1);
        repeat (32) @(posedge clk);
        #1;
        n_cmp++; if (data_resultRDY !== 1'b1) begin n_err++; $display("FAIL b2b_first_rdy: got %b exp 1", data_resultRDY); end
        pulse(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b1);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b exp 1", busy); end
        repeat (16) @(posedge clk);
        #1;
        n_cmp++; if (data_result !== 32'hFFFB_2E00) begin n_err++; $display("FAIL b2b_hold: got %h exp fffb2e00", data_result); end
        n_cmp++; if (data_resultRDY !== 1'b0) begin n_err++; $display("FAIL b2b_mid_rdy: got %b exp 0", data_resultRDY); end
        repeat (15) @(posedge clk);
        #1;
        n_cmp++; if (data_resultRDY !== 1'b0) begin n_err++; $display("FAIL b2b_early_rdy: got %b exp 0", data_resultRDY); end
        @(posedge clk); #1;
        n_cmp++; if (data_resultRDY !== 1'b1) begin n_err++; $display("FAIL b2b_second_rdy: got %b exp 1", data_resultRDY); end
        n_cmp++; if (data_result !== 32'h0000_0100) begin n_err++; $display("FAIL b2b_second_result: got %h exp 00000100", data_result); end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_random();
        test_abort();
        test_clear();
        test_back_to_back();
        repeat (4) @(posedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending exp 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
